// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
//
// 8N1 UART receiver (1 start bit, 8 data bits LSB first, 1 stop bit, idle-high
// line) for a 50 MHz system clock. Each bit is split into 16 subsamples. The
// start bit is re-checked mid-bit to reject glitches, and a low stop bit is
// reported as a framing error instead of a received byte.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN  - each bit value is the 2-of-3 majority of the
//                          subsamples taken as smp_cnt advances to 7, 8 and 9.
//                          The decision moves one subsample later. When it is
//                          undefined, a single sample is taken as smp_cnt
//                          advances to 8.
//
// Ports:
//   clk        in   system clock, 50 MHz
//   rst_n      in   synchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   baud_set   in   [2:0] 0=9600 1=19200 2=38400 3=57600 4=115200 (5-7 = 9600)
//   data_byte  out  [7:0] last byte received with a good stop bit
//   rx_done    out  one-cycle pulse when data_byte is updated
//   frame_err  out  one-cycle pulse when the stop bit samples 0
//   uart_state out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_byte_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Value of smp_cnt on the subsample strobe at which a bit value is decided.
  // The strobe fires while smp_cnt holds this value and advances it by one.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_SMP = 4'd8;
`else
  localparam logic [3:0] DECIDE_SMP = 4'd7;
`endif

  logic [1:0]  state;
  logic        rx_s1, rx_s2, rx_s3;
  logic        rx_fall;
  logic [15:0] tc_sel;
  logic [15:0] tc_q;
  logic [15:0] div_cnt;
  logic [3:0]  smp_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        sub_stb;
  logic        sample_stb;
  logic        bit_end;
  logic        bit_val;

  // ---------------------------------------------------------------------------
  // Synchronizer and falling-edge detector. Reset to the idle level so that
  // leaving reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  // NOTE: reset here is synchronous (sampled on clk); all state updates use
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  // ---------------------------------------------------------------------------
  // Subsample divisor terminal count for the requested rate.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tc_sel = 16'd324;
    case (baud_set)
      3'd1:    tc_sel = 16'd162;
      3'd2:    tc_sel = 16'd80;
      3'd3:    tc_sel = 16'd53;
      3'd4:    tc_sel = 16'd26;
      default: tc_sel = 16'd324;
    endcase
  end

  assign sub_stb    = (state != S_IDLE) && (div_cnt == tc_q);
  assign sample_stb = sub_stb && (smp_cnt == DECIDE_SMP);
  assign bit_end    = sub_stb && (smp_cnt == 4'd15);

  // ---------------------------------------------------------------------------
  // Bit value: single sample, or 2-of-3 majority around mid-bit.
  // ---------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
  logic smp_a, smp_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else if (sub_stb) begin
      if (smp_cnt == 4'd6) smp_a <= rx_s2;
      if (smp_cnt == 4'd7) smp_b <= rx_s2;
    end
  end

  assign bit_val = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);
`else
  assign bit_val = rx_s2;
`endif

  // ---------------------------------------------------------------------------
  // Frame state machine and counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tc_q      <= 16'd324;
      div_cnt   <= 16'd0;
      smp_cnt   <= 4'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      data_byte <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      if (state != S_IDLE) begin
        if (sub_stb) begin
          div_cnt <= 16'd0;
          smp_cnt <= smp_cnt + 4'd1;  // wraps 15 -> 0 at the bit boundary
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end

      case (state)
        S_IDLE: begin
          div_cnt <= 16'd0;
          smp_cnt <= 4'd0;
          bit_cnt <= 3'd0;
          if (rx_fall) begin
            state <= S_START;
            tc_q  <= tc_sel;  // rate is frozen for the whole frame
          end
        end

        S_START: begin
          if (sample_stb && bit_val) begin
            state <= S_IDLE;  // glitch, not a start bit
          end else if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= 3'd0;
          end
        end

        S_DATA: begin
          if (sample_stb) begin
            shreg[bit_cnt] <= bit_val;
          end
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        S_STOP: begin
          // Leaving at mid-stop-bit lets the next start edge be seen even
          // with zero idle time between frames.
          if (sample_stb) begin
            state <= S_IDLE;
            if (bit_val) begin
              data_byte <= shreg;
              rx_done   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign uart_state = (state != S_IDLE);

endmodule
